// File: rtl/program_loader.sv
// program_loader: turns a host byte stream into instruction-memory, data-memory
// and register-file writes for the pipeline core, and owns the core's reset.
// Packets: {cmd, addr, d0, d1} for writes (cmd 00/01/02); single-byte RUN (03)
// and HALT (07). Any other command byte raises the sticky err flag.
module program_loader #(
  parameter int IMEM_DEPTH = 16,
  parameter int DMEM_DEPTH = 16,
  parameter int NREGS      = 8,
  localparam int IAW = $clog2(IMEM_DEPTH),
  localparam int DAW = $clog2(DMEM_DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic           imem_we,
  output logic [IAW-1:0] imem_addr,
  output logic [8:0]     imem_wdata,
  output logic           dmem_we,
  output logic [DAW-1:0] dmem_addr,
  output logic [7:0]     dmem_wdata,
  output logic           rf_we,
  output logic [2:0]     rf_addr,
  output logic [7:0]     rf_wdata,
  output logic           cpu_rst,
  output logic           err,
  output logic [7:0]     write_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_D0,
    S_D1,
    S_COMMIT
  } state_t;

  state_t     state_q, state_d;
  logic       accept;
  logic       addr_ok;
  logic [1:0] cmd_q;
  logic [7:0] addr_q;
  logic [7:0] d0_q;

  // Ready everywhere except the single COMMIT cycle, and never while in reset.
  assign in_ready = !rst && (state_q != S_COMMIT);
  assign accept   = in_valid && in_ready;

  // Address range check for the packet currently being assembled.
  always_comb begin
    addr_ok = 1'b0;
    case (cmd_q)
      2'd0:    addr_ok = int'(addr_q) < IMEM_DEPTH;
      2'd1:    addr_ok = int'(addr_q) < DMEM_DEPTH;
      2'd2:    addr_ok = int'(addr_q) < NREGS;
      default: addr_ok = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: advance on each accepted byte; COMMIT always lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept && (in_data <= 8'h02)) state_d = S_ADDR;
      S_ADDR:   if (accept) state_d = S_D0;
      S_D0:     if (accept) state_d = S_D1;
      S_D1:     if (accept) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Packet capture, write strobes, core reset, error flag and write counter.
  // The strobe is registered on the edge that accepts d1, so it is high
  // exactly during the COMMIT cycle; d1 is taken straight from in_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q       <= '0;
      addr_q      <= '0;
      d0_q        <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      rf_we       <= 1'b0;
      rf_addr     <= '0;
      rf_wdata    <= '0;
      cpu_rst     <= 1'b1;
      err         <= 1'b0;
      write_count <= '0;
    end else begin
      imem_we <= 1'b0;
      dmem_we <= 1'b0;
      rf_we   <= 1'b0;
      if (accept) begin
        case (state_q)
          S_IDLE: begin
            case (in_data)
              8'h00, 8'h01, 8'h02: cmd_q <= in_data[1:0];
              8'h03:               cpu_rst <= 1'b0;
              8'h07: begin
                cpu_rst <= 1'b1;
                err     <= 1'b0;
              end
              default:             err <= 1'b1;
            endcase
          end
          S_ADDR: addr_q <= in_data;
          S_D0:   d0_q   <= in_data;
          S_D1: begin
            // Writes are refused while the core runs or when out of range.
            if (!cpu_rst || !addr_ok) begin
              err <= 1'b1;
            end else begin
              write_count <= write_count + 8'd1;
              case (cmd_q)
                2'd0: begin
                  imem_we    <= 1'b1;
                  imem_addr  <= addr_q[IAW-1:0];
                  imem_wdata <= {in_data[0], d0_q};
                end
                2'd1: begin
                  dmem_we    <= 1'b1;
                  dmem_addr  <= addr_q[DAW-1:0];
                  dmem_wdata <= d0_q;
                end
                default: begin
                  rf_we    <= 1'b1;
                  rf_addr  <= addr_q[2:0];
                  rf_wdata <= d0_q;
                end
              endcase
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a packet-level reference model checked
// against every DUT output on every cycle, plus literal expectations per test.
module tb_program_loader;

  logic       clk, rst, in_valid, in_ready;
  logic [7:0] in_data;
  logic       imem_we, dmem_we, rf_we, cpu_rst, err;
  logic [3:0] imem_addr, dmem_addr;
  logic [8:0] imem_wdata;
  logic [7:0] dmem_wdata, rf_wdata, write_count;
  logic [2:0] rf_addr;

  int checks = 0;
  int failures = 0;
  bit started = 0;

  program_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .rf_we(rf_we), .rf_addr(rf_addr),
    .rf_wdata(rf_wdata), .cpu_rst(cpu_rst), .err(err),
    .write_count(write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collects accepted bytes into a packet and applies the
  // command rules once the packet is complete.
  logic [7:0] pkt[$];
  bit         m_commit;
  logic       m_imem_we, m_dmem_we, m_rf_we, m_cpu_rst, m_err;
  logic [3:0] m_imem_addr, m_dmem_addr;
  logic [8:0] m_imem_wdata;
  logic [7:0] m_dmem_wdata, m_rf_wdata, m_count;
  logic [2:0] m_rf_addr;

  always @(posedge clk) begin
    int limit;
    bit ready;
    if (rst) begin
      pkt.delete();
      m_commit = 0;
      m_imem_we = 0; m_dmem_we = 0; m_rf_we = 0;
      m_imem_addr = 0; m_imem_wdata = 0; m_dmem_addr = 0; m_dmem_wdata = 0;
      m_rf_addr = 0; m_rf_wdata = 0;
      m_cpu_rst = 1; m_err = 0; m_count = 0;
    end else begin
      ready = !m_commit;
      m_commit = 0;
      m_imem_we = 0; m_dmem_we = 0; m_rf_we = 0;
      if (in_valid && ready) begin
        pkt.push_back(in_data);
        if (pkt.size() == 1) begin
          if (in_data == 8'h03) begin m_cpu_rst = 0; pkt.delete(); end
          else if (in_data == 8'h07) begin m_cpu_rst = 1; m_err = 0; pkt.delete(); end
          else if (in_data > 8'h02) begin m_err = 1; pkt.delete(); end
        end else if (pkt.size() == 4) begin
          limit = (pkt[0] == 0) ? 16 : (pkt[0] == 1) ? 16 : 8;
          if (int'(pkt[1]) >= limit || !m_cpu_rst) m_err = 1;
          else begin
            m_count = m_count + 1;
            if (pkt[0] == 0) begin
              m_imem_we = 1; m_imem_addr = pkt[1][3:0]; m_imem_wdata = {pkt[3][0], pkt[2]};
            end else if (pkt[0] == 1) begin
              m_dmem_we = 1; m_dmem_addr = pkt[1][3:0]; m_dmem_wdata = pkt[2];
            end else begin
              m_rf_we = 1; m_rf_addr = pkt[1][2:0]; m_rf_wdata = pkt[2];
            end
          end
          m_commit = 1;
          pkt.delete();
        end
      end
    end
  end

  // Strobe logs for the literal per-test expectations.
  logic [12:0] ev_imem[$];
  logic [11:0] ev_dmem[$];
  logic [10:0] ev_rf[$];

  // Compare process: every cycle, 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    if (started) begin
      chk("in_ready", in_ready, !rst && !m_commit);
      chk("imem_we", imem_we, m_imem_we);
      chk("imem_addr", imem_addr, m_imem_addr);
      chk("imem_wdata", imem_wdata, m_imem_wdata);
      chk("dmem_we", dmem_we, m_dmem_we);
      chk("dmem_addr", dmem_addr, m_dmem_addr);
      chk("dmem_wdata", dmem_wdata, m_dmem_wdata);
      chk("rf_we", rf_we, m_rf_we);
      chk("rf_addr", rf_addr, m_rf_addr);
      chk("rf_wdata", rf_wdata, m_rf_wdata);
      chk("cpu_rst", cpu_rst, m_cpu_rst);
      chk("err", err, m_err);
      chk("write_count", write_count, m_count);
      if (imem_we === 1'b1) ev_imem.push_back({imem_addr, imem_wdata});
      if (dmem_we === 1'b1) ev_dmem.push_back({dmem_addr, dmem_wdata});
      if (rf_we === 1'b1)   ev_rf.push_back({rf_addr, rf_wdata});
    end
  end

  // Present one byte from a falling edge, hold until accepted, then idle gap cycles.
  task automatic send(input logic [7:0] b, input int gap);
    bit r;
    bit done = 0;
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      r = in_ready;
      @(negedge clk);
      if (r) done = 1;
    end
    if (!done) begin
      failures++;
      $display("FAIL send_timeout: byte %0h not accepted, expected acceptance", b);
    end
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] c, input logic [7:0] a,
                          input logic [7:0] x0, input logic [7:0] x1, input int gap);
    send(c, gap); send(a, gap); send(x0, gap); send(x1, gap);
  endtask

  task automatic clear_logs();
    ev_imem.delete(); ev_dmem.delete(); ev_rf.delete();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    started = 1;
    chk("ready_in_reset", in_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cpu_rst", cpu_rst, 1'b1);
    chk("rst_err", err, 1'b0);
    chk("rst_count", write_count, 8'd0);
    chk("ready_after_rst", in_ready, 1'b1);

    // Load ADD/LOAD/SUB back to back.
    clear_logs();
    send_pkt(8'h00, 8'h00, 8'h0A, 8'h00, 0);
    send_pkt(8'h00, 8'h01, 8'h9C, 8'h00, 0);
    send_pkt(8'h00, 8'h02, 8'h4B, 8'h00, 0);
    repeat (3) @(negedge clk);
    chk("t1_nev", ev_imem.size(), 3);
    if (ev_imem.size() == 3) begin
      chk("t1_ev0", ev_imem[0], {4'd0, 9'h00A});
      chk("t1_ev1", ev_imem[1], {4'd1, 9'h09C});
      chk("t1_ev2", ev_imem[2], {4'd2, 9'h04B});
    end
    chk("t1_count", write_count, 8'd3);
    chk("t1_cpu_rst", cpu_rst, 1'b1);

    // Bit-8 instruction.
    clear_logs();
    send_pkt(8'h00, 8'h03, 8'h01, 8'h01, 0);
    repeat (2) @(negedge clk);
    chk("t2_nev", ev_imem.size(), 1);
    if (ev_imem.size() == 1) chk("t2_ev", ev_imem[0], {4'd3, 9'h101});

    // Data + register preload, then RUN.
    clear_logs();
    send_pkt(8'h01, 8'h04, 8'h14, 8'h00, 0);
    send_pkt(8'h02, 8'h01, 8'h0A, 8'h00, 0);
    send_pkt(8'h02, 8'h02, 8'h05, 8'h00, 0);
    repeat (2) @(negedge clk);
    chk("t3_cpu_rst_before", cpu_rst, 1'b1);
    send(8'h03, 0);
    chk("t3_cpu_rst_after", cpu_rst, 1'b0);
    chk("t3_ndmem", ev_dmem.size(), 1);
    if (ev_dmem.size() == 1) chk("t3_dmem", ev_dmem[0], {4'd4, 8'd20});
    chk("t3_nrf", ev_rf.size(), 2);
    if (ev_rf.size() == 2) begin
      chk("t3_rf0", ev_rf[0], {3'd1, 8'd10});
      chk("t3_rf1", ev_rf[1], {3'd2, 8'd5});
    end
    chk("t3_count", write_count, 8'd7);

    // Error cases.
    send(8'h07, 0);
    chk("halt_cpu_rst", cpu_rst, 1'b1);
    clear_logs();
    send_pkt(8'h01, 8'h10, 8'hAA, 8'h00, 0);
    repeat (2) @(negedge clk);
    chk("oor_nev", ev_dmem.size(), 0);
    chk("oor_err", err, 1'b1);
    chk("oor_count", write_count, 8'd7);
    send(8'h07, 0);
    chk("halt_clr_err", err, 1'b0);
    send(8'h55, 0);
    chk("badcmd_err", err, 1'b1);
    send(8'h07, 0);
    send(8'h03, 0);
    clear_logs();
    send_pkt(8'h00, 8'h07, 8'h11, 8'h00, 0);
    repeat (2) @(negedge clk);
    chk("run_write_nev", ev_imem.size(), 0);
    chk("run_write_err", err, 1'b1);
    send(8'h07, 0);
    chk("halt2_err", err, 1'b0);
    chk("halt2_cpu_rst", cpu_rst, 1'b1);

    // Stalls of 3 cycles between bytes.
    clear_logs();
    send_pkt(8'h00, 8'h05, 8'h0A, 8'h00, 3);
    chk("stall_nev", ev_imem.size(), 1);
    if (ev_imem.size() == 1) chk("stall_ev", ev_imem[0], {4'd5, 9'h00A});
    chk("stall_count", write_count, 8'd8);

    // Next command byte presented during COMMIT must not be lost.
    clear_logs();
    send_pkt(8'h02, 8'h03, 8'h07, 8'h00, 0);
    send_pkt(8'h01, 8'h02, 8'h33, 8'h00, 0);
    repeat (2) @(negedge clk);
    chk("hold_nrf", ev_rf.size(), 1);
    if (ev_rf.size() == 1) chk("hold_rf", ev_rf[0], {3'd3, 8'h07});
    chk("hold_ndmem", ev_dmem.size(), 1);
    if (ev_dmem.size() == 1) chk("hold_dmem", ev_dmem[0], {4'd2, 8'h33});
    chk("hold_count", write_count, 8'd10);

    // Reset in the middle of a packet.
    clear_logs();
    send(8'h00, 0);
    send(8'h06, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(8'h0A, 0);
    send(8'h00, 0);
    repeat (3) @(negedge clk);
    chk("midrst_nev", ev_imem.size(), 0);
    chk("midrst_err", err, 1'b1);
    chk("midrst_cpu_rst", cpu_rst, 1'b1);
    chk("midrst_count", write_count, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
